// File: rtl/fmadd_normalize_seq_if.sv
// Handshake bundle between the FMADD adder stage, the post-addition
// normalizer and the rounding stage.
//   in_*  : raw sum beat (valid/ready) from the mantissa adder
//   out_* : normalized beat (valid/ready) toward the rounder
// Modports:
//   slave  : normalizer view (consumes in_*, produces out_*)
//   master : environment view (produces in_*, consumes out_*)
interface fmadd_normalize_seq_if #(
  parameter int man = 22,
  parameter int exp = 7
);
  localparam int W  = 2*man + 4;
  localparam int EW = exp + 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mantissa;
  logic          in_carry;
  logic [EW-1:0] in_exponent;
  logic          in_sign;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_mantissa;
  logic [EW-1:0] out_exponent;
  logic          out_sign;
  logic          out_sticky;
  logic          out_zero;
  logic          out_overflow;
  logic          out_denormal;

  modport slave (
    input  in_valid, in_mantissa, in_carry, in_exponent, in_sign, out_ready,
    output in_ready, out_valid, out_mantissa, out_exponent, out_sign,
           out_sticky, out_zero, out_overflow, out_denormal
  );

  modport master (
    output in_valid, in_mantissa, in_carry, in_exponent, in_sign, out_ready,
    input  in_ready, out_valid, out_mantissa, out_exponent, out_sign,
           out_sticky, out_zero, out_overflow, out_denormal
  );
endinterface

// File: rtl/fmadd_normalize_seq.sv
// Post-addition normalizer for the FMADD datapath.
// Takes the raw adder sum ({carry, mantissa}, exponent, sign), brings the
// leading one to bit W-2 by right shifting (carry/overflowed integer part)
// or iterative left shifting (coarse STEP, then single bits), adjusts the
// exponent, gathers a sticky bit and hands the result to the rounder.
// Ports:
//   clk   : rising-edge clock
//   rst_l : asynchronous active-low reset
//   bus   : fmadd_normalize_seq_if.slave (in_* beat in, out_* beat out)
module fmadd_normalize_seq #(
  parameter int man  = 22,
  parameter int exp  = 7,
  parameter int STEP = 8
) (
  input logic                  clk,
  input logic                  rst_l,
  fmadd_normalize_seq_if.slave bus
);
  localparam int W  = 2*man + 4;
  localparam int EW = exp + 1;

  localparam logic [EW:0] EMAX       = (EW+1)'((1 << EW) - 1);
  localparam logic [EW:0] E_ONE      = (EW+1)'(1);
  localparam logic [EW:0] E_TWO      = (EW+1)'(2);
  localparam logic [EW:0] E_STEP     = (EW+1)'(STEP);
  localparam logic [EW:0] E_STEP_MIN = (EW+1)'(STEP + 1);

  typedef enum logic [2:0] {IDLE, PRE, CHK, SHIFT, DONE} state_t;

  state_t        state, state_n;
  logic [W:0]    mant, mant_n;
  logic [EW:0]   e, e_n;
  logic          sticky, sticky_n;
  logic          sign_q, sign_n;
  logic          zero_f, zero_n;
  logic          ovf_f, ovf_n;
  logic          den_f, den_n;
  logic          done;

  // Clamp an exponent that has run past the largest code.
  function automatic logic [EW:0] exp_saturate(input logic [EW:0] e_in);
    return (e_in >= EMAX) ? EMAX : e_in;
  endfunction

  // Control: state and result flags
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state  <= IDLE;
      zero_f <= 1'b0;
      ovf_f  <= 1'b0;
      den_f  <= 1'b0;
    end else begin
      state  <= state_n;
      zero_f <= zero_n;
      ovf_f  <= ovf_n;
      den_f  <= den_n;
    end
  end

  // Datapath: mantissa, exponent, sticky and sign
  always_ff @(posedge clk) begin
    mant   <= mant_n;
    e      <= e_n;
    sticky <= sticky_n;
    sign_q <= sign_n;
  end

  always_comb begin
    state_n  = state;
    mant_n   = mant;
    e_n      = e;
    sticky_n = sticky;
    sign_n   = sign_q;
    zero_n   = zero_f;
    ovf_n    = ovf_f;
    den_n    = den_f;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          mant_n   = {bus.in_carry, bus.in_mantissa};
          e_n      = {1'b0, bus.in_exponent};
          sign_n   = bus.in_sign;
          sticky_n = 1'b0;
          zero_n   = 1'b0;
          ovf_n    = 1'b0;
          den_n    = 1'b0;
          state_n  = PRE;
        end
      end
      PRE: begin
        if (mant == '0) begin
          zero_n  = 1'b1;
          e_n     = '0;
          state_n = DONE;
        end else if (mant[W]) begin
          mant_n   = mant >> 2;
          e_n      = e + E_TWO;
          sticky_n = sticky | (|mant[1:0]);
          state_n  = CHK;
        end else if (mant[W-1]) begin
          mant_n   = mant >> 1;
          e_n      = e + E_ONE;
          sticky_n = sticky | mant[0];
          state_n  = CHK;
        end else if (mant[W-2]) begin
          state_n = DONE;
        end else if (e <= E_ONE) begin
          den_n   = 1'b1;
          e_n     = '0;
          state_n = DONE;
        end else begin
          state_n = SHIFT;
        end
      end
      CHK: begin
        // A right shift may have pushed the exponent to/past the top code.
        if (e >= EMAX) begin
          ovf_n    = 1'b1;
          mant_n   = '0;
          sticky_n = 1'b0;
        end
        e_n     = exp_saturate(e);
        state_n = DONE;
      end
      SHIFT: begin
        if (mant[W-2]) begin
          state_n = DONE;
        end else if (e <= E_ONE) begin
          den_n   = 1'b1;
          e_n     = '0;
          state_n = DONE;
        end else if ((mant[W-2:W-1-STEP] == '0) && (e > E_STEP_MIN)) begin
          // Window is empty, so a STEP jump cannot overshoot bit W-2,
          // and the exponent guard keeps it from crossing the floor.
          mant_n = mant << STEP;
          e_n    = e - E_STEP;
        end else begin
          mant_n = mant << 1;
          e_n    = e - E_ONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign done             = (state == DONE);
  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = done;
  assign bus.out_mantissa = done ? mant[W-1:0]  : '0;
  assign bus.out_exponent = done ? e[EW-1:0]    : '0;
  assign bus.out_sign     = done ? sign_q       : 1'b0;
  assign bus.out_sticky   = done ? sticky       : 1'b0;
  assign bus.out_zero     = done ? zero_f       : 1'b0;
  assign bus.out_overflow = done ? ovf_f        : 1'b0;
  assign bus.out_denormal = done ? den_f        : 1'b0;
endmodule

// File: tb/tb_fmadd_normalize_seq.sv
module tb_fmadd_normalize_seq;
  localparam int MAN  = 22;
  localparam int EXPW = 7;
  localparam int STEP = 8;
  localparam int LAT_MAX = 16;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  fmadd_normalize_seq_if #(.man(MAN), .exp(EXPW)) bus ();

  fmadd_normalize_seq #(.man(MAN), .exp(EXPW), .STEP(STEP)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [47:0] m;
    logic [7:0]  e;
    logic        s;
    logic        st;
    logic        z;
    logic        o;
    logic        d;
  } res_t;

  function automatic res_t get_out();
    res_t r;
    r.m  = bus.out_mantissa;
    r.e  = bus.out_exponent;
    r.s  = bus.out_sign;
    r.st = bus.out_sticky;
    r.z  = bus.out_zero;
    r.o  = bus.out_overflow;
    r.d  = bus.out_denormal;
    return r;
  endfunction

  // Reference: normalize by total shift distance instead of iterating.
  function automatic res_t model(input logic [47:0] m, input logic c,
                                 input logic [7:0] e, input logic s);
    res_t r;
    logic [48:0] v;
    int ei, p, d, avail, sh;
    r = '0;
    r.s = s;
    v = {c, m};
    ei = int'(e);
    if (v == 49'd0) begin
      r.z = 1'b1;
    end else if (v[48] | v[47]) begin
      sh = v[48] ? 2 : 1;
      r.st = |(v & ((49'd1 << sh) - 49'd1));
      v = v >> sh;
      ei += sh;
      if (ei >= 255) begin
        r.o = 1'b1;
        r.e = 8'd255;
        r.st = 1'b0;
      end else begin
        r.m = v[47:0];
        r.e = 8'(ei);
      end
    end else begin
      p = 0;
      for (int i = 0; i < 48; i++) if (m[i]) p = i;
      d = 46 - p;
      avail = (ei > 1) ? ei - 1 : 0;
      if (d <= avail) begin
        r.m = m << d;
        r.e = 8'(ei - d);
      end else begin
        r.m = m << avail;
        r.d = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic drive_in(input logic [47:0] m, input logic c,
                          input logic [7:0] e, input logic s);
    bus.in_mantissa = m;
    bus.in_carry    = c;
    bus.in_exponent = e;
    bus.in_sign     = s;
    bus.in_valid    = 1'b1;
  endtask

  // One beat through the block; lat counts edges from accept (=1) to out_valid.
  task automatic run_beat(input logic [47:0] m, input logic c, input logic [7:0] e,
                          input logic s, output res_t got, output int lat);
    int guard;
    @(negedge clk);
    drive_in(m, c, e, s);
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = get_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    res_t got, expv;
    int lat;
    logic seen;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_mantissa = '0;
    bus.in_carry = 1'b0;
    bus.in_exponent = '0;
    bus.in_sign = 1'b0;
    rst_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || get_out() !== res_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b out=%h want valid=0 out=0", bus.out_valid, get_out());
    end
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    // Start a long left-shift beat, then reset while it is shifting.
    @(negedge clk);
    drive_in(48'h0000_0000_0100, 1'b0, 8'd120, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || get_out() !== res_t'(0) || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset got valid=%b ready=%b out=%h want valid=0 ready=1 out=0",
               bus.out_valid, bus.in_ready, get_out());
    end
    @(negedge clk);
    rst_l = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_no_partial got seen=%b ready=%b want seen=0 ready=1", seen, bus.in_ready);
    end
    expv = model(48'h0000_1234_5678, 1'b0, 8'd77, 1'b0);
    run_beat(48'h0000_1234_5678, 1'b0, 8'd77, 1'b0, got, lat);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL post_reset_beat got %h want %h", got, expv);
    end
  endtask

  task automatic test_carry();
    res_t got, expv;
    int lat;
    expv = model(48'h0, 1'b1, 8'd100, 1'b0);
    run_beat(48'h0, 1'b1, 8'd100, 1'b0, got, lat);
    checks++;
    if (got !== expv || got.m !== 48'h4000_0000_0000 || got.e !== 8'd102 || got.st !== 1'b0) begin
      errors++;
      $display("FAIL carry got %h want %h", got, expv);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL carry_latency got %0d want 3", lat);
    end
  endtask

  task automatic test_right_shift();
    res_t got, expv;
    int lat;
    expv = model(48'h8000_0000_0001, 1'b0, 8'd100, 1'b1);
    run_beat(48'h8000_0000_0001, 1'b0, 8'd100, 1'b1, got, lat);
    checks++;
    if (got !== expv || got.m !== 48'h4000_0000_0000 || got.e !== 8'd101 || got.st !== 1'b1) begin
      errors++;
      $display("FAIL right_shift got %h want %h", got, expv);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL right_shift_latency got %0d want 3", lat);
    end
    run_beat(48'h4000_0000_00ff, 1'b0, 8'd50, 1'b0, got, lat);
    checks++;
    if (got !== model(48'h4000_0000_00ff, 1'b0, 8'd50, 1'b0) || lat != 2) begin
      errors++;
      $display("FAIL already_normal got %h lat %0d want %h lat 2", got, lat,
               model(48'h4000_0000_00ff, 1'b0, 8'd50, 1'b0));
    end
  endtask

  task automatic test_coarse_left();
    res_t got, expv;
    int lat;
    expv = model(48'h0000_0000_0100, 1'b0, 8'd120, 1'b0);
    run_beat(48'h0000_0000_0100, 1'b0, 8'd120, 1'b0, got, lat);
    checks++;
    if (got !== expv || got.m !== 48'h4000_0000_0000 || got.e !== 8'd82 || got.st !== 1'b0) begin
      errors++;
      $display("FAIL coarse_left got %h want %h", got, expv);
    end
    checks++;
    if (lat < 3 || lat > LAT_MAX) begin
      errors++;
      $display("FAIL coarse_left_latency got %0d want 3..%0d", lat, LAT_MAX);
    end
  endtask

  task automatic test_floor_zero_overflow();
    res_t got, expv;
    int lat;
    expv = model(48'h0000_0000_0100, 1'b0, 8'd10, 1'b0);
    run_beat(48'h0000_0000_0100, 1'b0, 8'd10, 1'b0, got, lat);
    checks++;
    if (got !== expv || got.d !== 1'b1 || got.e !== 8'd0 || got.m !== 48'h0000_0002_0000) begin
      errors++;
      $display("FAIL denormal got %h want %h", got, expv);
    end
    run_beat(48'h0, 1'b0, 8'd90, 1'b1, got, lat);
    checks++;
    if (got.z !== 1'b1 || got.o !== 1'b0 || got.d !== 1'b0 || got.e !== 8'd0 ||
        got.m !== 48'h0 || got.s !== 1'b1 || lat != 2) begin
      errors++;
      $display("FAIL zero got %h lat %0d want %h lat 2", got, lat, model(48'h0, 1'b0, 8'd90, 1'b1));
    end
    expv = model(48'h0, 1'b1, 8'd254, 1'b0);
    run_beat(48'h0, 1'b1, 8'd254, 1'b0, got, lat);
    checks++;
    if (got !== expv || got.o !== 1'b1 || got.e !== 8'd255 || got.z !== 1'b0 || got.d !== 1'b0) begin
      errors++;
      $display("FAIL overflow got %h want %h", got, expv);
    end
  endtask

  task automatic test_backpressure();
    res_t exp1, exp2, held, got;
    int lat;
    logic bad;
    exp1 = model(48'h0000_0000_1234, 1'b0, 8'd90, 1'b1);
    exp2 = model(48'h9abc_def0_1234, 1'b1, 8'd30, 1'b0);
    @(negedge clk);
    drive_in(48'h0000_0000_1234, 1'b0, 8'd90, 1'b1);
    @(posedge clk);
    #1;
    // Second beat is offered immediately and held while the first stalls.
    drive_in(48'h9abc_def0_1234, 1'b1, 8'd30, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    held = get_out();
    checks++;
    if (held !== exp1 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first got %h valid %b want %h valid 1", held, bus.out_valid, exp1);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (get_out() !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL bp_stable got unstable=%b want 0", bad);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept got ready=%b want 0", bus.in_ready);
    end
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = get_out();
    checks++;
    if (got !== exp2 || lat != 3) begin
      errors++;
      $display("FAIL bp_second got %h lat %0d want %h lat 3", got, lat, exp2);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    res_t got, expv;
    int lat, kind;
    logic [63:0] t;
    logic [47:0] m;
    logic c;
    logic [7:0] e;
    logic s;
    for (int n = 0; n < 150; n++) begin
      t = {$urandom(), $urandom()};
      kind = $urandom_range(0, 5);
      c = 1'b0;
      case (kind)
        0: m = 48'h0;
        1: begin m = t[47:0]; c = 1'b1; end
        2: m = {1'b1, t[46:0]};
        3: m = {2'b01, t[45:0]};
        default: begin
          m = t[47:0] >> $urandom_range(2, 47);
          if (m == 48'h0) m = 48'h1;
        end
      endcase
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      expv = model(m, c, e, s);
      run_beat(m, c, e, s, got, lat);
      checks++;
      if (got !== expv || lat < 2 || lat > LAT_MAX) begin
        errors++;
        $display("FAIL random[%0d] in m=%h c=%b e=%0d got %h lat %0d want %h", n, m, c, e, got, lat, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_right_shift();
    test_coarse_left();
    test_floor_zero_overflow();
    test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
